// File: rtl/regfile_arbiter.sv
// Two-requester arbiter in front of a 2-read/1-write register file.
// Alternates under contention, supports bounded ownership locks, and flags forced releases.
module regfile_arbiter #(
    parameter int DW       = 16,
    parameter int AW       = 3,
    parameter int LOCK_MAX = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          wr0,
    input  logic          wr1,
    input  logic          lock0,
    input  logic          lock1,
    input  logic [AW-1:0] rx0,
    input  logic [AW-1:0] ry0,
    input  logic [AW-1:0] wa0,
    input  logic [AW-1:0] rx1,
    input  logic [AW-1:0] ry1,
    input  logic [AW-1:0] wa1,
    input  logic [DW-1:0] wd0,
    input  logic [DW-1:0] wd1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdx,
    output logic [DW-1:0] rdy,
    output logic          lock_err0,
    output logic          lock_err1,
    output logic          rf_wr_en,
    output logic [AW-1:0] rf_rx,
    output logic [AW-1:0] rf_ry,
    output logic [AW-1:0] rf_w_r,
    output logic [DW-1:0] rf_data_in,
    input  logic [DW-1:0] rf_datax,
    input  logic [DW-1:0] rf_datay
);

    localparam int CW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);

    typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_t;

    state_t        state, state_next;
    logic          last, last_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          err0_next, err1_next;
    logic          lock_sel;

    // The register file registers its reads, so read data passes straight through.
    assign rdx = rf_datax;
    assign rdy = rf_datay;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves one unassigned (no latch).
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        state_next = state;
        cnt_next   = cnt;
        last_next  = last;
        err0_next  = 1'b0;
        err1_next  = 1'b0;

        if (reset) begin
            case (state)
                ARB: begin
                    if (req0 && req1) begin
                        gnt0 = last;
                        gnt1 = !last;
                    end else begin
                        gnt0 = req0;
                        gnt1 = req1;
                    end
                end
                LOCK0:   gnt0 = req0;
                LOCK1:   gnt1 = req1;
                default: ;
            endcase
        end

        lock_sel = gnt1 ? lock1 : lock0;
        if (gnt0 || gnt1) last_next = gnt1;

        case (state)
            ARB: begin
                cnt_next = '0;
                if (gnt0 && lock0)      state_next = LOCK0;
                else if (gnt1 && lock1) state_next = LOCK1;
            end
            LOCK0, LOCK1: begin
                if ((gnt0 || gnt1) && !lock_sel) begin
                    state_next = ARB;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    // Forced release: a transfer this cycle still completes but cannot re-lock.
                    state_next = ARB;
                    cnt_next   = '0;
                    err0_next  = (state == LOCK0);
                    err1_next  = (state == LOCK1);
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = ARB;
        endcase
    end

    always_comb begin
        rf_wr_en   = 1'b0;
        rf_rx      = '0;
        rf_ry      = '0;
        rf_w_r     = '0;
        rf_data_in = '0;
        if (gnt0) begin
            rf_wr_en   = wr0;
            rf_rx      = rx0;
            rf_ry      = ry0;
            rf_w_r     = wa0;
            rf_data_in = wd0;
        end else if (gnt1) begin
            rf_wr_en   = wr1;
            rf_rx      = rx1;
            rf_ry      = ry1;
            rf_w_r     = wa1;
            rf_data_in = wd1;
        end
    end

    // last resets to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ARB;
            last      <= 1'b1;
            cnt       <= '0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            lock_err0 <= 1'b0;
            lock_err1 <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state     <= state_next;
            last      <= last_next;
            cnt       <= cnt_next;
            rvalid0   <= gnt0;
            rvalid1   <= gnt1;
            lock_err0 <= err0_next;
            lock_err1 <= err1_next;
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Randomized scoreboard bench for regfile_arbiter with a behavioural register file
// and a transaction-level reference model of arbitration, locking and read data.
module tb_regfile_arbiter;

    localparam int DW       = 16;
    localparam int AW       = 3;
    localparam int LOCK_MAX = 8;
    localparam int NREG     = 1 << AW;

    typedef struct packed {
        logic          req;
        logic          wr;
        logic          lock;
        logic [AW-1:0] rx;
        logic [AW-1:0] ry;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
    } op_t;

    typedef struct packed {
        logic          g0, g1, wr_en;
        logic [AW-1:0] rx, ry, w;
        logic [DW-1:0] din;
        logic          rv0, rv1, le0, le1;
    } cyc_t;

    typedef struct packed {
        logic          id;
        logic [DW-1:0] x, y;
    } rd_t;

    logic          clk, reset;
    logic          req0, req1, wr0, wr1, lock0, lock1;
    logic [AW-1:0] rx0, ry0, wa0, rx1, ry1, wa1;
    logic [DW-1:0] wd0, wd1;
    logic          gnt0, gnt1, rvalid0, rvalid1, lock_err0, lock_err1;
    logic [DW-1:0] rdx, rdy;
    logic          rf_wr_en;
    logic [AW-1:0] rf_rx, rf_ry, rf_w_r;
    logic [DW-1:0] rf_data_in, rf_datax, rf_datay;

    regfile_arbiter #(.DW(DW), .AW(AW), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1), .lock0(lock0), .lock1(lock1),
        .rx0(rx0), .ry0(ry0), .wa0(wa0), .rx1(rx1), .ry1(ry1), .wa1(wa1),
        .wd0(wd0), .wd1(wd1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdx(rdx), .rdy(rdy), .lock_err0(lock_err0), .lock_err1(lock_err1),
        .rf_wr_en(rf_wr_en), .rf_rx(rf_rx), .rf_ry(rf_ry), .rf_w_r(rf_w_r),
        .rf_data_in(rf_data_in), .rf_datax(rf_datax), .rf_datay(rf_datay)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register file: registered reads, read-before-write on the same edge.
    logic [DW-1:0] mem [NREG];
    always @(posedge clk) begin
        rf_datax <= mem[rf_rx];
        rf_datay <= mem[rf_ry];
        if (rf_wr_en) mem[rf_w_r] <= rf_data_in;
    end

    // Reference model state.
    logic [DW-1:0] ref_rf [NREG];
    int  owner;      // -1: nobody holds a lock
    int  age;        // cycles already spent under the current lock
    bit  last_m;
    bit  pv0, pv1, pe0, pe1;

    cyc_t exp_cyc[$];
    rd_t  exp_rd[$];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic op_t mk(input bit rq, input bit w, input bit lk, input int x, input int y,
                               input int a, input logic [DW-1:0] d);
        op_t o;
        o.req = rq; o.wr = w; o.lock = lk;
        o.rx = AW'(x); o.ry = AW'(y); o.wa = AW'(a); o.wd = d;
        return o;
    endfunction

    function automatic op_t rand_op(input int req_pct);
        op_t o;
        o.req  = ($urandom_range(0, 99) < req_pct);
        o.wr   = $urandom_range(0, 1) == 1;
        o.lock = $urandom_range(0, 2) == 0;
        o.rx   = AW'($urandom_range(0, NREG - 1));
        o.ry   = AW'($urandom_range(0, NREG - 1));
        o.wa   = AW'($urandom_range(0, NREG - 1));
        o.wd   = DW'($urandom);
        return o;
    endfunction

    // Drive one cycle of stimulus and queue what the DUT must show in that cycle.
    task automatic step(input bit rst_v, input op_t o0, input op_t o1);
        cyc_t e;
        rd_t  r;
        op_t  o;
        bit   g0, g1, xfer, winner;
        @(posedge clk);
        #1;
        reset = rst_v;
        req0 = o0.req; wr0 = o0.wr; lock0 = o0.lock; rx0 = o0.rx; ry0 = o0.ry; wa0 = o0.wa; wd0 = o0.wd;
        req1 = o1.req; wr1 = o1.wr; lock1 = o1.lock; rx1 = o1.rx; ry1 = o1.ry; wa1 = o1.wa; wd1 = o1.wd;
        e = '0;
        if (!rst_v) begin
            owner = -1; age = 0; last_m = 1'b1;
            pv0 = 0; pv1 = 0; pe0 = 0; pe1 = 0;
            exp_rd.delete();
            exp_cyc.push_back(e);
            return;
        end
        e.rv0 = pv0; e.rv1 = pv1; e.le0 = pe0; e.le1 = pe1;

        g0 = 0; g1 = 0;
        if (owner == 0) g0 = o0.req;
        else if (owner == 1) g1 = o1.req;
        else if (o0.req && o1.req) begin
            winner = !last_m;
            g0 = (winner == 0);
            g1 = (winner == 1);
        end else begin
            g0 = o0.req;
            g1 = o1.req;
        end
        xfer = g0 || g1;
        o = g1 ? o1 : o0;
        e.g0 = g0; e.g1 = g1;
        pv0 = g0; pv1 = g1; pe0 = 0; pe1 = 0;

        if (xfer) begin
            e.wr_en = o.wr; e.rx = o.rx; e.ry = o.ry; e.w = o.wa; e.din = o.wd;
            r.id = g1; r.x = ref_rf[o.rx]; r.y = ref_rf[o.ry];
            exp_rd.push_back(r);
            if (o.wr) ref_rf[o.wa] = o.wd;
            last_m = g1;
        end

        if (owner < 0) begin
            if (xfer && o.lock) begin
                owner = g1 ? 1 : 0;
                age = 0;
            end
        end else if (xfer && !o.lock) begin
            owner = -1;
        end else if (age == LOCK_MAX - 1) begin
            if (owner == 0) pe0 = 1; else pe1 = 1;
            owner = -1;
        end else begin
            age++;
        end
        exp_cyc.push_back(e);
    endtask

    // Monitor: compares every cycle's outputs against the queued expectations.
    cyc_t me;
    rd_t  mr;
    always @(negedge clk) begin
        if (exp_cyc.size() != 0) begin
            me = exp_cyc.pop_front();
            check("gnt0", gnt0, me.g0);
            check("gnt1", gnt1, me.g1);
            check("rf_wr_en", rf_wr_en, me.wr_en);
            check("rf_rx", rf_rx, me.rx);
            check("rf_ry", rf_ry, me.ry);
            check("rf_w_r", rf_w_r, me.w);
            check("rf_data_in", rf_data_in, me.din);
            check("rvalid0", rvalid0, me.rv0);
            check("rvalid1", rvalid1, me.rv1);
            check("lock_err0", lock_err0, me.le0);
            check("lock_err1", lock_err1, me.le1);
            if (rvalid0 || rvalid1) begin
                if (exp_rd.size() == 0) begin
                    check("rvalid_unexpected", 32'd1, 32'd0);
                end else begin
                    mr = exp_rd.pop_front();
                    check("rd_owner", rvalid1, mr.id);
                    check("rdx", rdx, mr.x);
                    check("rdy", rdy, mr.y);
                end
            end
        end
    end

    op_t idle;

    initial begin
        idle  = '0;
        reset = 1'b0;
        req0 = 0; wr0 = 0; lock0 = 0; rx0 = '0; ry0 = '0; wa0 = '0; wd0 = '0;
        req1 = 0; wr1 = 0; lock1 = 0; rx1 = '0; ry1 = '0; wa1 = '0; wd1 = '0;
        owner = -1; age = 0; last_m = 1'b1;
        pv0 = 0; pv1 = 0; pe0 = 0; pe1 = 0;
        for (int i = 0; i < NREG; i++) begin
            mem[i]    = DW'(16'h1000 + i);
            ref_rf[i] = DW'(16'h1000 + i);
        end

        // Reset held with both requesting: no grant may escape.
        step(0, mk(1, 1, 0, 1, 2, 3, 16'h1111), mk(1, 1, 0, 4, 5, 6, 16'h2222));
        step(0, mk(1, 1, 0, 1, 2, 3, 16'h1111), mk(1, 1, 0, 4, 5, 6, 16'h2222));

        // Two-way contention without locks alternates 0,1,0,1.
        for (int i = 0; i < 4; i++)
            step(1, mk(1, 0, 0, i, i + 1, 0, 16'h0), mk(1, 0, 0, i + 2, i + 3, 0, 16'h0));
        step(1, idle, idle);

        // Write r3 while reading it (old value), then read the new value.
        step(1, mk(1, 1, 0, 3, 3, 3, 16'h00A5), idle);
        step(1, mk(1, 0, 0, 3, 3, 0, 16'h0), idle);
        step(1, idle, idle);

        // Requester 0 holds a lock while requester 1 waits.
        step(1, mk(1, 0, 1, 1, 2, 0, 16'h0), idle);
        for (int i = 0; i < 3; i++)
            step(1, mk(1, 1, 1, 0, 1, i, DW'(16'h0300 + i)), mk(1, 0, 0, 5, 6, 0, 16'h0));
        step(1, mk(1, 0, 0, 2, 3, 0, 16'h0), mk(1, 0, 0, 5, 6, 0, 16'h0));
        step(1, idle, mk(1, 0, 0, 5, 6, 0, 16'h0));
        step(1, idle, idle);

        // Requester 1 locks and goes idle; the lock is forcibly released.
        step(1, idle, mk(1, 1, 1, 0, 0, 7, 16'h0777));
        for (int i = 0; i < LOCK_MAX + 3; i++)
            step(1, mk(1, 0, 0, 7, 3, 0, 16'h0), idle);
        step(1, idle, idle);

        // Reset pulse right after a transfer, then contention goes to requester 0.
        step(1, mk(1, 1, 0, 2, 4, 2, 16'h0BEE), idle);
        step(0, mk(1, 0, 0, 1, 1, 0, 16'h0), mk(1, 0, 0, 1, 1, 0, 16'h0));
        step(1, mk(1, 0, 0, 2, 2, 0, 16'h0), mk(1, 0, 0, 3, 3, 0, 16'h0));
        step(1, idle, idle);

        // Random traffic, alternating busy and sparse request phases.
        for (int c = 0; c < 3000; c++) begin
            int pct;
            pct = ((c / 200) % 2 == 0) ? 80 : 25;
            step(($urandom_range(0, 299) != 0), rand_op(pct), rand_op(pct));
        end

        step(1, idle, idle);
        step(1, idle, idle);
        @(negedge clk);
        #1;
        check("cyc_queue_drained", exp_cyc.size(), 0);
        check("rd_queue_drained", exp_rd.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
